// File: rtl/sar_sample_buffer_if.sv
// Capture/readout bus of sar_sample_buffer: conversion input side plus valid/ready drain side.
interface sar_sample_buffer_if #(
  parameter int DW = 12,
  parameter int AW = 3
);
  logic          ENABLE;
  logic          EOC;
  logic [0:DW-1] DIN;
  logic          RD_READY;
  logic          CLR_OVF;
  logic          RD_VALID;
  logic [DW-1:0] RD_DATA;
  logic [AW:0]   COUNT;
  logic          FULL;
  logic          OVF;

  modport master (
    output ENABLE, EOC, DIN, RD_READY, CLR_OVF,
    input  RD_VALID, RD_DATA, COUNT, FULL, OVF
  );
  modport slave (
    input  ENABLE, EOC, DIN, RD_READY, CLR_OVF,
    output RD_VALID, RD_DATA, COUNT, FULL, OVF
  );
endinterface

// File: rtl/sar_sample_buffer.sv
// FWFT FIFO capturing one SAR result per EOC rise; sticky overflow on dropped captures.
// Define SAR_AVG_EN to push the truncated mean of every 2^AVG_LOG2 captures instead.
module sar_sample_buffer #(
  parameter int DW       = 12,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int AVG_LOG2 = 2
)(
  input  logic          CLK,
  input  logic          RST_N,
  sar_sample_buffer_if.slave bus
);
  if (DEPTH != (1 << AW) || DEPTH < 2 || AVG_LOG2 < 1) begin : g_bad_param
    $error("sar_sample_buffer: DEPTH must be 2**AW (>=2) and AVG_LOG2 >= 1");
  end

  logic          eoc_d, cap;
  logic [DW-1:0] din_w, push_data;
  logic          push_req, push, pop, drop, full;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [DW-1:0] mem [DEPTH];

  // DIN is ascending-range; copy bit by bit so w[k] = DIN[k] (LSB stays LSB)
  for (genvar k = 0; k < DW; k++) begin : g_bitmap
    assign din_w[k] = bus.DIN[k];
  end

  assign cap = bus.ENABLE & bus.EOC & ~eoc_d;

`ifdef SAR_AVG_EN
  localparam int SW = DW + AVG_LOG2;
  logic [SW-1:0]       acc, sum;
  logic [AVG_LOG2-1:0] phase;

  assign sum       = acc + SW'(din_w);
  assign push_req  = cap & (&phase);
  assign push_data = DW'(sum >> AVG_LOG2);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc   <= '0;
      phase <= '0;
    end else if (!bus.ENABLE) begin
      acc   <= '0;
      phase <= '0;
    end else if (cap) begin
      acc   <= (&phase) ? '0 : sum;
      phase <= phase + 1'b1;
    end
  end
`else
  assign push_req  = cap;
  assign push_data = din_w;
`endif

  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = bus.RD_VALID & bus.RD_READY;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      eoc_d  <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      eoc_d <= bus.EOC;
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop)             ovf <= 1'b1;
      else if (bus.CLR_OVF) ovf <= 1'b0;
    end
  end

  assign bus.RD_VALID = (count != '0);
  assign bus.RD_DATA  = mem[rd_ptr];
  assign bus.COUNT    = count;
  assign bus.FULL     = full;
  assign bus.OVF      = ovf;
endmodule

// File: tb/tb_sar_sample_buffer.sv
// Directed bench for sar_sample_buffer: vector table plus fill/overflow/drain sequences.
module tb_sar_sample_buffer;
  localparam int CLK_NS = 10;
  localparam int DW = 12, DEPTH = 8, AW = 3;
  localparam bit H = 1'b1, L = 1'b0;

  logic CLK = 1'b0;
  logic RST_N;
  always #(CLK_NS/2) CLK = ~CLK;

  sar_sample_buffer_if #(.DW(DW), .AW(AW)) bus ();
  sar_sample_buffer #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .AVG_LOG2(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  typedef struct {
    bit          en, eoc;
    logic [0:11] din;
    bit          rdy, clr;
    bit          vld;
    logic [11:0] data;
    logic [3:0]  cnt;
    bit          full, ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic logic [0:DW-1] to_din(input logic [DW-1:0] v);
    logic [0:DW-1] r;
    for (int k = 0; k < DW; k++) r[k] = v[k];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input bit vld, input int cnt, input bit fl, input bit ov);
    chk({tag, ".vld"},   int'(bus.RD_VALID), int'(vld));
    chk({tag, ".count"}, int'(bus.COUNT),    cnt);
    chk({tag, ".full"},  int'(bus.FULL),     int'(fl));
    chk({tag, ".ovf"},   int'(bus.OVF),      int'(ov));
  endtask

  task automatic cap_pulse(input logic [DW-1:0] v);
    bus.EOC = 1'b1; bus.DIN = to_din(v); tick();
    bus.EOC = 1'b0; tick();
  endtask

  task automatic drain(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.head%0d", tag, i), int'(bus.RD_DATA), first + i);
      bus.RD_READY = 1'b1; tick();
      bus.RD_READY = 1'b0;
    end
  endtask

  vec_t tbl[13];

  initial begin
    bus.ENABLE = 1'b1; bus.EOC = 1'b1; bus.DIN = '0;
    bus.RD_READY = 1'b0; bus.CLR_OVF = 1'b0;
    RST_N = 1'b0;
    #(CLK_NS*2 + 2);
    chk("reset.data", int'(bus.RD_DATA), 0);
    chk_state("reset", L, 0, L, L);
    @(negedge CLK); RST_N = 1'b1;

`ifdef SAR_AVG_EN
    bus.EOC = 1'b0; tick();
    cap_pulse(12'd100); cap_pulse(12'd101); cap_pulse(12'd102);
    chk_state("avg3", L, 0, L, L);
    bus.EOC = 1'b1; bus.DIN = to_din(12'd104); tick();
    chk_state("avg4", H, 1, L, L);
    chk("avg4.data", int'(bus.RD_DATA), 101);
    bus.EOC = 1'b0; tick();
`else
    //         en eoc din                   rdy clr  vld data     cnt   full ovf
    tbl[0]  = '{H, H, to_din(12'h000),     L,  L,   L, 12'h000, 4'd0, L, L}; // EOC high at release
    tbl[1]  = '{H, H, to_din(12'h000),     L,  L,   L, 12'h000, 4'd0, L, L};
    tbl[2]  = '{H, L, to_din(12'h000),     L,  L,   L, 12'h000, 4'd0, L, L};
    tbl[3]  = '{H, H, 12'b1000_0000_0001,  L,  L,   H, 12'h801, 4'd1, L, L};
    tbl[4]  = '{H, L, 12'b0000_0000_0000,  H,  L,   L, 12'h000, 4'd0, L, L};
    tbl[5]  = '{H, H, 12'b0000_0000_0001,  L,  L,   H, 12'h800, 4'd1, L, L}; // DIN[11] is MSB
    tbl[6]  = '{H, H, 12'b0000_0000_0001,  H,  L,   L, 12'h000, 4'd0, L, L};
    tbl[7]  = '{H, H, 12'b0000_0000_0001,  L,  L,   L, 12'h000, 4'd0, L, L}; // still high
    tbl[8]  = '{H, L, to_din(12'h000),     L,  L,   L, 12'h000, 4'd0, L, L};
    tbl[9]  = '{L, H, to_din(12'h005),     L,  L,   L, 12'h000, 4'd0, L, L}; // disabled rise
    tbl[10] = '{L, L, to_din(12'h005),     L,  L,   L, 12'h000, 4'd0, L, L};
    tbl[11] = '{H, H, to_din(12'hA5C),     H,  L,   H, 12'hA5C, 4'd1, L, L}; // ready while empty
    tbl[12] = '{H, L, to_din(12'h000),     H,  L,   L, 12'h000, 4'd0, L, L};

    for (int i = 0; i < 13; i++) begin
      bus.ENABLE = tbl[i].en; bus.EOC = tbl[i].eoc; bus.DIN = tbl[i].din;
      bus.RD_READY = tbl[i].rdy; bus.CLR_OVF = tbl[i].clr;
      tick();
      chk_state($sformatf("vec%0d", i), tbl[i].vld, int'(tbl[i].cnt), tbl[i].full, tbl[i].ovf);
      if (tbl[i].vld) chk($sformatf("vec%0d.data", i), int'(bus.RD_DATA), int'(tbl[i].data));
    end
    bus.RD_READY = 1'b0; bus.ENABLE = 1'b1; bus.EOC = 1'b0;

    // overflow: nine captures into eight slots, oldest eight survive
    for (int v = 1; v <= 8; v++) cap_pulse(DW'(v));
    chk_state("fill8", H, 8, H, L);
    cap_pulse(12'h009);
    chk_state("ovf9", H, 8, H, H);
    drain("drain9", 1, 8);
    chk_state("drained", L, 0, L, H);
    bus.CLR_OVF = 1'b1; tick(); bus.CLR_OVF = 1'b0;
    chk("clr_ovf", int'(bus.OVF), 0);

    // full + simultaneous pop: push accepted, then set beats clear on a drop
    for (int v = 16; v < 24; v++) cap_pulse(DW'(v));
    chk_state("refill", H, 8, H, L);
    bus.EOC = 1'b1; bus.DIN = to_din(12'h018); bus.RD_READY = 1'b1; tick();
    bus.EOC = 1'b0; bus.RD_READY = 1'b0;
    chk_state("pushpop", H, 8, H, L);
    tick();
    bus.EOC = 1'b1; bus.DIN = to_din(12'h019); bus.CLR_OVF = 1'b1; tick();
    bus.EOC = 1'b0; bus.CLR_OVF = 1'b0;
    chk_state("setprio", H, 8, H, H);
    tick();
    drain("drain18", 17, 8);
    chk_state("end", L, 0, L, H);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(CLK_NS * 5000);
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
